// File: rtl/mm_rd_seq_if.sv
// mm_rd_seq_if - command and operand-read bus of the MM read sequencer.
//   slave  : sequencer side. It takes the command fields and mxu_rdy, and drives
//            cmd_rdy, both read streams, mm_done and busy.
//   master : decode/MXU side, the mirror image of slave.
//   Signals: cmd_vld/cmd_rdy handshake; {iram,wram}_{start_addr,col_dir,row_dir,
//            col_len,row_len} command fields; mxu_rdy beat acceptance;
//            {iram,wram}_rd_{vld,addr} read beats; mm_done; busy.
interface mm_rd_seq_if #(
  parameter int ADDR_W = 12
);
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [ADDR_W-1:0] iram_start_addr;
  logic              iram_col_dir;
  logic              iram_row_dir;
  logic [3:0]        iram_col_len;
  logic [3:0]        iram_row_len;
  logic [ADDR_W-1:0] wram_start_addr;
  logic              wram_col_dir;
  logic              wram_row_dir;
  logic [3:0]        wram_col_len;
  logic [3:0]        wram_row_len;
  logic              mxu_rdy;
  logic              iram_rd_vld;
  logic [ADDR_W-1:0] iram_rd_addr;
  logic              wram_rd_vld;
  logic [ADDR_W-1:0] wram_rd_addr;
  logic              mm_done;
  logic              busy;

  modport slave (
    input  cmd_vld, iram_start_addr, iram_col_dir, iram_row_dir, iram_col_len,
           iram_row_len, wram_start_addr, wram_col_dir, wram_row_dir,
           wram_col_len, wram_row_len, mxu_rdy,
    output cmd_rdy, iram_rd_vld, iram_rd_addr, wram_rd_vld, wram_rd_addr,
           mm_done, busy
  );

  modport master (
    output cmd_vld, iram_start_addr, iram_col_dir, iram_row_dir, iram_col_len,
           iram_row_len, wram_start_addr, wram_col_dir, wram_row_dir,
           wram_col_len, wram_row_len, mxu_rdy,
    input  cmd_rdy, iram_rd_vld, iram_rd_addr, wram_rd_vld, wram_rd_addr,
           mm_done, busy
  );
endinterface

// File: rtl/mm_rd_seq.sv
// mm_rd_seq - matrix-multiply operand read sequencer.
// The block accepts one MM command and walks IRAM and WRAM in lockstep. Column
// is the inner loop and row is the outer loop. Each accepted beat (RUN and
// mxu_rdy) produces one read address per stream. A stream with fewer beats
// drops its vld and holds its last address. After the final beat the block
// spends one cycle in DONE with mm_done high, then returns to IDLE.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : mm_rd_seq_if.slave (command fields, mxu_rdy, read streams,
//                cmd_rdy, mm_done, busy)
module mm_rd_seq #(
  parameter int ADDR_W     = 12,
  parameter int ROW_STRIDE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mm_rd_seq_if.slave      bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Walk configuration that is latched with the command.
  typedef struct packed {
    logic       col_dir;
    logic       row_dir;
    logic [3:0] col_len;
    logic [3:0] row_len;
  } cfg_t;

  // Live position of one stream. row_base is the address of column 0 in the
  // current row, so a row step never has to undo the column offset.
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] row_base;
    logic [3:0]        col;
    logic [3:0]        row;
  } strm_t;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ROW_STRIDE);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  state_t r_state, w_state_nxt;
  cfg_t   r_cfg_i, r_cfg_w;
  strm_t  r_str_i, r_str_w;

  logic w_cmd_acc, w_beat_acc, w_last_i, w_last_w, w_last_beat;

  function automatic logic at_end(input strm_t s, input cfg_t c);
    return s.vld && (s.col == c.col_len) && (s.row == c.row_len);
  endfunction

  // Position after one accepted, non-final beat. A stream that is already
  // exhausted keeps vld low and holds its address.
  function automatic strm_t step(input strm_t s, input cfg_t c);
    strm_t n;
    n = s;
    if (s.vld) begin
      if (s.col != c.col_len) begin
        n.col  = s.col + 4'd1;
        n.addr = c.col_dir ? s.addr - ONE : s.addr + ONE;
      end else if (s.row != c.row_len) begin
        n.col      = 4'd0;
        n.row      = s.row + 4'd1;
        n.row_base = c.row_dir ? s.row_base - STRIDE : s.row_base + STRIDE;
        n.addr     = n.row_base;
      end else begin
        n.vld = 1'b0;
      end
    end
    return n;
  endfunction

  assign w_cmd_acc   = (r_state == S_IDLE) && bus.cmd_vld;
  assign w_beat_acc  = (r_state == S_RUN) && bus.mxu_rdy;
  assign w_last_i    = at_end(r_str_i, r_cfg_i);
  assign w_last_w    = at_end(r_str_w, r_cfg_w);
  // The final beat is reached when each stream is either on its last beat or
  // already exhausted. The total count is therefore max(N_iram, N_wram).
  assign w_last_beat = (!r_str_i.vld || w_last_i) && (!r_str_w.vld || w_last_w);

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default assignment at the top of this block covers every path,
  // so no latch is inferred for w_state_nxt.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.cmd_vld) w_state_nxt = S_RUN;
      S_RUN:   if (w_beat_acc && w_last_beat) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_i <= '0;
      r_cfg_w <= '0;
      r_str_i <= '0;
      r_str_w <= '0;
    end else if (w_cmd_acc) begin
      r_cfg_i <= '{col_dir: bus.iram_col_dir, row_dir: bus.iram_row_dir,
                   col_len: bus.iram_col_len, row_len: bus.iram_row_len};
      r_cfg_w <= '{col_dir: bus.wram_col_dir, row_dir: bus.wram_row_dir,
                   col_len: bus.wram_col_len, row_len: bus.wram_row_len};
      r_str_i <= '{vld: 1'b1, addr: bus.iram_start_addr,
                   row_base: bus.iram_start_addr, col: 4'd0, row: 4'd0};
      r_str_w <= '{vld: 1'b1, addr: bus.wram_start_addr,
                   row_base: bus.wram_start_addr, col: 4'd0, row: 4'd0};
    end else if (w_beat_acc) begin
      if (w_last_beat) begin
        // Entering DONE: both streams go quiet and the addresses hold.
        r_str_i.vld <= 1'b0;
        r_str_w.vld <= 1'b0;
      end else begin
        r_str_i <= step(r_str_i, r_cfg_i);
        r_str_w <= step(r_str_w, r_cfg_w);
      end
    end
  end

  assign bus.cmd_rdy      = (r_state == S_IDLE);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.mm_done      = (r_state == S_DONE);
  assign bus.iram_rd_vld  = r_str_i.vld;
  assign bus.iram_rd_addr = r_str_i.addr;
  assign bus.wram_rd_vld  = r_str_w.vld;
  assign bus.wram_rd_addr = r_str_w.addr;

endmodule

// File: tb/tb_mm_rd_seq.sv
// tb_mm_rd_seq - self-checking bench for mm_rd_seq. It applies a table of
// directed commands with hand-computed address sequences. It also has
// hand-written sequences for backpressure, back-to-back commands and reset
// in the middle of a run.
module tb_mm_rd_seq;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mm_rd_seq_if #(.ADDR_W(AW)) bus ();

  mm_rd_seq #(.ADDR_W(AW), .ROW_STRIDE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [11:0]       i_start;
    logic              i_cdir, i_rdir;
    logic [3:0]        i_cl, i_rl;
    logic [11:0]       w_start;
    logic              w_cdir, w_rdir;
    logic [3:0]        w_cl, w_rl;
    int                n_i, n_w;
    logic [0:7][11:0]  i_exp;
    logic [0:7][11:0]  w_exp;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [6];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [11:0] i_start, input logic i_cdir, input logic i_rdir,
    input logic [3:0] i_cl, input logic [3:0] i_rl,
    input logic [11:0] w_start, input logic w_cdir, input logic w_rdir,
    input logic [3:0] w_cl, input logic [3:0] w_rl,
    input int n_i, input int n_w,
    input logic [0:7][11:0] i_exp, input logic [0:7][11:0] w_exp);
    vec_t v;
    v.i_start = i_start; v.i_cdir = i_cdir; v.i_rdir = i_rdir;
    v.i_cl = i_cl; v.i_rl = i_rl;
    v.w_start = w_start; v.w_cdir = w_cdir; v.w_rdir = w_rdir;
    v.w_cl = w_cl; v.w_rl = w_rl;
    v.n_i = n_i; v.n_w = n_w; v.i_exp = i_exp; v.w_exp = w_exp;
    return v;
  endfunction

  task automatic present(input vec_t v);
    bus.iram_start_addr = v.i_start;
    bus.iram_col_dir    = v.i_cdir;
    bus.iram_row_dir    = v.i_rdir;
    bus.iram_col_len    = v.i_cl;
    bus.iram_row_len    = v.i_rl;
    bus.wram_start_addr = v.w_start;
    bus.wram_col_dir    = v.w_cdir;
    bus.wram_row_dir    = v.w_rdir;
    bus.wram_col_len    = v.w_cl;
    bus.wram_row_len    = v.w_rl;
  endtask

  task automatic check_reset_outputs(input int idx);
    check("rst_cmd_rdy", idx, bus.cmd_rdy, 1);
    check("rst_busy", idx, bus.busy, 0);
    check("rst_done", idx, bus.mm_done, 0);
    check("rst_i_vld", idx, bus.iram_rd_vld, 0);
    check("rst_i_addr", idx, bus.iram_rd_addr, 0);
    check("rst_w_vld", idx, bus.wram_rd_vld, 0);
    check("rst_w_addr", idx, bus.wram_rd_addr, 0);
  endtask

  task automatic check_idle(input int idx);
    check("idle_cmd_rdy", idx, bus.cmd_rdy, 1);
    check("idle_busy", idx, bus.busy, 0);
    check("idle_done", idx, bus.mm_done, 0);
  endtask

  // Entered at the negedge of the cycle where beat 0 is visible. When
  // k == stall_beat, mxu_rdy is held low for stall_cycles cycles, so that
  // beat stays visible for stall_cycles+1 cycles. The task returns at the
  // negedge of the cycle after DONE.
  task automatic run_beats(input vec_t v, input int stall_beat,
                           input int stall_cycles);
    int nb;
    nb = (v.n_i > v.n_w) ? v.n_i : v.n_w;
    for (int k = 0; k < nb; k++) begin
      logic        iv, wv;
      logic [11:0] ia, wa;
      int          hold;
      iv   = (k < v.n_i);
      wv   = (k < v.n_w);
      ia   = iv ? v.i_exp[k] : v.i_exp[v.n_i-1];
      wa   = wv ? v.w_exp[k] : v.w_exp[v.n_w-1];
      hold = (k == stall_beat) ? stall_cycles : 0;
      for (int h = 0; h <= hold; h++) begin
        bus.mxu_rdy = (h == hold);
        check("i_vld", k, bus.iram_rd_vld, iv);
        check("i_addr", k, bus.iram_rd_addr, ia);
        check("w_vld", k, bus.wram_rd_vld, wv);
        check("w_addr", k, bus.wram_rd_addr, wa);
        check("run_done", k, bus.mm_done, 0);
        check("run_cmd_rdy", k, bus.cmd_rdy, 0);
        @(negedge clk);
      end
    end
    check("done_pulse", nb, bus.mm_done, 1);
    check("done_i_vld", nb, bus.iram_rd_vld, 0);
    check("done_w_vld", nb, bus.wram_rd_vld, 0);
    check("done_i_addr", nb, bus.iram_rd_addr, v.i_exp[v.n_i-1]);
    check("done_w_addr", nb, bus.wram_rd_addr, v.w_exp[v.n_w-1]);
    check("done_busy", nb, bus.busy, 1);
    check("done_cmd_rdy", nb, bus.cmd_rdy, 0);
    @(negedge clk);
  endtask

  task automatic run_cmd(input vec_t v, input int idx, input int stall_beat,
                         input int stall_cycles);
    present(v);
    bus.cmd_vld = 1'b1;
    check("pre_cmd_rdy", idx, bus.cmd_rdy, 1);
    @(negedge clk);
    bus.cmd_vld = 1'b0;
    run_beats(v, stall_beat, stall_cycles);
    check_idle(idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(12'h100, 1'b0, 1'b0, 4'd0, 4'd0, 12'h200, 1'b0, 1'b0, 4'd0, 4'd0,
                 1, 1, {12'h100, {7{12'h000}}}, {12'h200, {7{12'h000}}});
    vecs[1] = mk(12'h010, 1'b0, 1'b0, 4'd3, 4'd1, 12'h040, 1'b0, 1'b0, 4'd1, 4'd1,
                 8, 4,
                 {12'h010, 12'h011, 12'h012, 12'h013, 12'h020, 12'h021, 12'h022, 12'h023},
                 {12'h040, 12'h041, 12'h050, 12'h051, {4{12'h000}}});
    vecs[2] = mk(12'h001, 1'b1, 1'b1, 4'd2, 4'd1, 12'h005, 1'b0, 1'b1, 4'd1, 4'd2,
                 6, 6,
                 {12'h001, 12'h000, 12'hFFF, 12'hFF1, 12'hFF0, 12'hFEF, {2{12'h000}}},
                 {12'h005, 12'h006, 12'hFF5, 12'hFF6, 12'hFE5, 12'hFE6, {2{12'h000}}});
    vecs[3] = mk(12'hFFE, 1'b0, 1'b0, 4'd3, 4'd0, 12'h300, 1'b1, 1'b0, 4'd0, 4'd4,
                 4, 5,
                 {12'hFFE, 12'hFFF, 12'h000, 12'h001, {4{12'h000}}},
                 {12'h300, 12'h310, 12'h320, 12'h330, 12'h340, {3{12'h000}}});
    vecs[4] = mk(12'hFE8, 1'b0, 1'b0, 4'd1, 4'd1, 12'hFF0, 1'b0, 1'b0, 4'd0, 4'd3,
                 4, 4,
                 {12'hFE8, 12'hFE9, 12'hFF8, 12'hFF9, {4{12'h000}}},
                 {12'hFF0, 12'h000, 12'h010, 12'h020, {4{12'h000}}});
    vecs[5] = mk(12'h0A3, 1'b1, 1'b0, 4'd2, 4'd1, 12'h7FF, 1'b0, 1'b1, 4'd1, 4'd3,
                 6, 8,
                 {12'h0A3, 12'h0A2, 12'h0A1, 12'h0B3, 12'h0B2, 12'h0B1, {2{12'h000}}},
                 {12'h7FF, 12'h800, 12'h7EF, 12'h7F0, 12'h7DF, 12'h7E0, 12'h7CF, 12'h7D0});

    rst_n       = 1'b0;
    bus.cmd_vld = 1'b0;
    bus.mxu_rdy = 1'b1;
    present(vecs[0]);
    #3;
    check_reset_outputs(0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs(1);

    // Directed table, mxu_rdy held high.
    for (int i = 0; i < 6; i++) run_cmd(vecs[i], i, -1, 0);

    // Backpressure: beat 2 of the 2x4 case is visible for 4 cycles.
    run_cmd(vecs[1], 10, 2, 3);

    // Back-to-back: cmd_vld stays high and new fields are presented while
    // busy. Those fields must not disturb the running command, and they must
    // be accepted as soon as cmd_rdy comes back.
    present(vecs[2]);
    bus.cmd_vld = 1'b1;
    @(negedge clk);
    present(vecs[3]);
    run_beats(vecs[2], -1, 0);
    check_idle(20);
    @(negedge clk);
    bus.cmd_vld = 1'b0;
    run_beats(vecs[3], -1, 0);
    check_idle(21);

    // Reset mid-run: a 16-beat command (4x4 on both streams) aborted at beat 3.
    bus.iram_start_addr = 12'h400; bus.iram_col_dir = 1'b0; bus.iram_row_dir = 1'b0;
    bus.iram_col_len    = 4'd3;    bus.iram_row_len = 4'd3;
    bus.wram_start_addr = 12'h500; bus.wram_col_dir = 1'b0; bus.wram_row_dir = 1'b0;
    bus.wram_col_len    = 4'd3;    bus.wram_row_len = 4'd3;
    bus.cmd_vld = 1'b1;
    @(negedge clk);
    bus.cmd_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("rr_i_addr", k, bus.iram_rd_addr, 32'h400 + k);
      check("rr_w_addr", k, bus.wram_rd_addr, 32'h500 + k);
      check("rr_busy", k, bus.busy, 1);
      if (k < 3) @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs(30);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_no_done", k, bus.mm_done, 0);
      check("rr_idle_busy", k, bus.busy, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs(31);
    run_cmd(vecs[1], 32, -1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
